// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one combinational EX-stage ALU between two requesters
// and returns each result on a single tagged response channel with backpressure.
module alu_share_arbiter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [3:0]      req0_ctrl,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [3:0]      req1_ctrl,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    output logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_zero,
    output logic            rsp_err
);

    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic            last_grant;
    logic            lat_id;
    logic            lat_err;

    logic            accept;
    logic            sel;
    logic [3:0]      sel_ctrl;
    logic [XLEN-1:0] sel_a;
    logic [XLEN-1:0] sel_b;
    logic            sel_legal;

    // Grant: a lone requester wins; on a tie the one opposite last_grant wins.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!rst && state == IDLE) begin
            req0_ready = req0_valid && (!req1_valid || last_grant);
            req1_ready = req1_valid && (!req0_valid || !last_grant);
        end
    end

    // Payload of the granted requester and legality of its op code.
    always_comb begin
        accept    = req0_ready | req1_ready;
        sel       = req1_ready;
        sel_ctrl  = sel ? req1_ctrl : req0_ctrl;
        sel_a     = sel ? req1_a : req0_a;
        sel_b     = sel ? req1_b : req0_b;
        sel_legal = (sel_ctrl == OP_ADD) || (sel_ctrl == OP_SUB) ||
                    (sel_ctrl == OP_AND) || (sel_ctrl == OP_OR);
    end

    // Sequencer: ALU operands are loaded on accept so they are live exactly during EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            lat_id     <= 1'b0;
            lat_err    <= 1'b0;
            alu_ctrl   <= OP_ADD;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        last_grant <= sel;
                        lat_id     <= sel;
                        lat_err    <= !sel_legal;
                        // Illegal ops run a harmless 0+0 so the ALU never sees a stray code.
                        alu_ctrl   <= sel_legal ? sel_ctrl : OP_ADD;
                        alu_a      <= sel_legal ? sel_a : '0;
                        alu_b      <= sel_legal ? sel_b : '0;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= lat_id;
                    rsp_data  <= lat_err ? '0 : alu_result;
                    rsp_zero  <= lat_err ? 1'b1 : alu_zero;
                    rsp_err   <= lat_err;
                    alu_ctrl  <= OP_ADD;
                    alu_a     <= '0;
                    alu_b     <= '0;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed plus randomized bench for alu_share_arbiter with a behavioural ALU and
// a result/arbitration reference model derived from the op table and grant rules.
module tb_alu_share_arbiter;

    localparam int unsigned XLEN = 32;
    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0110;
    localparam logic [3:0] AND = 4'b0000;
    localparam logic [3:0] OR  = 4'b0001;

    logic            clk;
    logic            rst;
    logic            req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]      req0_ctrl, req1_ctrl;
    logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] alu_a, alu_b, alu_result;
    logic            alu_zero;
    logic            rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
    logic [XLEN-1:0] rsp_data;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_acc = 0;
    logic lg_model;

    alu_share_arbiter #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Shared EX-stage ALU as seen by the arbiter.
    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            ADD:     alu_result = alu_a + alu_b;
            SUB:     alu_result = alu_a - alu_b;
            AND:     alu_result = alu_a & alu_b;
            OR:      alu_result = alu_a | alu_b;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void ref_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] d, output logic z, output logic e);
        e = 1'b0;
        case (c)
            ADD:     d = a + b;
            SUB:     d = a - b;
            AND:     d = a & b;
            OR:      d = a | b;
            default: begin d = 32'd0; e = 1'b1; end
        endcase
        z = (d == 32'd0);
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_id"},    32'(rsp_id),    32'd0);
        check({tag, "_rsp_data"},  rsp_data,       32'd0);
        check({tag, "_rsp_zero"},  32'(rsp_zero),  32'd0);
        check({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
        check({tag, "_alu_ctrl"},  32'(alu_ctrl),  32'(ADD));
        check({tag, "_alu_a"},     alu_a,          32'd0);
        check({tag, "_alu_b"},     alu_b,          32'd0);
    endtask

    // One full transaction from request to response handshake; caller sits at posedge+1 in IDLE.
    task automatic run_op(input logic v0, input logic [3:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                          input logic v1, input logic [3:0] c1, input logic [31:0] a1, input logic [31:0] b1,
                          input int hold, input logic chk_tput);
        logic        gid;
        logic [3:0]  c;
        logic [31:0] a, b, ed;
        logic        ez, ee;
        req0_valid = v0; req0_ctrl = c0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_ctrl = c1; req1_a = a1; req1_b = b1;
        gid = (v0 && v1) ? !lg_model : v1;
        c = gid ? c1 : c0;
        a = gid ? a1 : a0;
        b = gid ? b1 : b0;
        ref_op(c, a, b, ed, ez, ee);
        #1;
        check("grant_req0", 32'(req0_ready), 32'(!gid));
        check("grant_req1", 32'(req1_ready), 32'(gid));
        @(posedge clk); #1;
        if (chk_tput) check("throughput", 32'(cyc - last_acc), 32'd3);
        last_acc = cyc;
        lg_model = gid;
        if (gid) req1_valid = 1'b0; else req0_valid = 1'b0;
        check("exec_alu_ctrl", 32'(alu_ctrl), ee ? 32'(ADD) : 32'(c));
        check("exec_alu_a", alu_a, ee ? 32'd0 : a);
        check("exec_alu_b", alu_b, ee ? 32'd0 : b);
        check("exec_ready", 32'({req0_ready, req1_ready}), 32'd0);
        check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        rsp_ready = (hold == 0);
        @(posedge clk); #1;
        for (int i = 0; i <= hold; i++) begin
            check("rsp_valid", 32'(rsp_valid), 32'd1);
            check("rsp_id", 32'(rsp_id), 32'(gid));
            check("rsp_data", rsp_data, ed);
            check("rsp_zero", 32'(rsp_zero), 32'(ez));
            check("rsp_err", 32'(rsp_err), 32'(ee));
            check("rsp_no_ready", 32'({req0_ready, req1_ready}), 32'd0);
            if (i < hold) begin
                @(posedge clk); #1;
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("rsp_done", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_ctrl = ADD; req0_a = '0; req0_b = '0;
        req1_valid = 1'b1; req1_ctrl = ADD; req1_a = '0; req1_b = '0;
        lg_model = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 32'({req0_ready, req1_ready}), 32'd0);
        check_reset_outputs("reset");
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(1'b1, ADD, 32'd5, 32'd7, 1'b0, ADD, 32'd0, 32'd0, 0, 1'b0);
        run_op(1'b0, ADD, 32'd0, 32'd0, 1'b1, SUB, 32'h1234, 32'h1234, 4, 1'b0);
        run_op(1'b1, 4'b1111, 32'hDEAD, 32'hBEEF, 1'b0, ADD, 32'd0, 32'd0, 0, 1'b0);
        run_op(1'b1, ADD, 32'hFFFF_FFFF, 32'd1, 1'b0, ADD, 32'd0, 32'd0, 1, 1'b0);

        // Reset while in EXEC drops the transaction.
        req0_valid = 1'b1; req0_ctrl = ADD; req0_a = 32'd1; req0_b = 32'd2;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        lg_model = 1'b1;
        check_reset_outputs("rst_exec");
        rst = 1'b0;

        // Reset while in RESP with the consumer stalled.
        req1_valid = 1'b1; req1_ctrl = SUB; req1_a = 32'd9; req1_b = 32'd4;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
        req0_valid = 1'b1; req1_valid = 1'b1;
        rst = 1'b1;
        #1;
        check("rst_resp_ready", 32'({req0_ready, req1_ready}), 32'd0);
        @(posedge clk); #1;
        lg_model = 1'b1;
        check_reset_outputs("rst_resp");
        rst = 1'b0;

        // Continuous tie: grants alternate starting with req0.
        for (int k = 0; k < 4; k++)
            run_op(1'b1, AND, 32'hF0F0, 32'h0FF0, 1'b1, OR, 32'hF000, 32'h000F, 0, k != 0);
        req0_valid = 1'b0; req1_valid = 1'b0;

        for (int k = 0; k < 24; k++) begin
            logic        v0, v1;
            logic [3:0]  c0, c1;
            logic [3:0]  ops [5];
            ops[0] = ADD; ops[1] = SUB; ops[2] = AND; ops[3] = OR; ops[4] = 4'($urandom);
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v0 = 1'b1;
            c0 = ops[$urandom_range(0, 4)];
            c1 = ops[$urandom_range(0, 4)];
            run_op(v0, c0, $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                   v1, c1, $urandom, $urandom, $urandom_range(0, 3), 1'b0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
